// File: rtl/flex_timer_pkg.sv
// Shared direction encodings and timer mode type for the flex timer.
package flex_timer_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    AUTO_RELOAD = 1'b0,
    ONE_SHOT    = 1'b1
  } timer_mode_t;

endpackage

// File: rtl/flex_timer_if.sv
// Configuration/status bundle between the register block (master) and the timer (slave).
interface flex_timer_if #(
  parameter int unsigned NUM_CNT_BITS  = 8,
  parameter int unsigned PRESCALE_BITS = 4
);

  logic                     clear;
  logic                     enable;
  logic                     count_down;
  logic                     one_shot;
  logic [PRESCALE_BITS-1:0] prescale;
  logic [NUM_CNT_BITS-1:0]  rollover_val;
  logic                     load;
  logic [NUM_CNT_BITS-1:0]  load_val;
  logic [NUM_CNT_BITS-1:0]  count_out;
  logic                     rollover_flag;
  logic                     done;
  logic                     running;

  modport master (
    output clear, enable, count_down, one_shot, prescale, rollover_val, load, load_val,
    input  count_out, rollover_flag, done, running
  );

  modport slave (
    input  clear, enable, count_down, one_shot, prescale, rollover_val, load, load_val,
    output count_out, rollover_flag, done, running
  );

endinterface

// File: rtl/flex_prescaler.sv
// Divides enabled cycles: tick fires on every (prescale+1)-th enabled cycle.
module flex_prescaler #(
  parameter int unsigned PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [PRESCALE_BITS-1:0] prescale,
  output logic                     tick
);

  logic [PRESCALE_BITS-1:0] pcnt_q, pcnt_d;

  // Prescale count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

  // Next count and tick; a lowered prescale simply lets pcnt wrap through its full width.
  always_comb begin
    pcnt_d = pcnt_q;
    tick   = 1'b0;
    if (clear) begin
      pcnt_d = '0;
    end else if (enable) begin
      if (pcnt_q == prescale) begin
        tick   = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PRESCALE_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/flex_timer.sv
// Up/down timer with prescaler, one-shot/auto-reload modes, load and sticky done flag.
module flex_timer
  import flex_timer_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS  = 8,
  parameter int unsigned PRESCALE_BITS = 4
) (
  input logic       clk,
  input logic       n_rst,
  flex_timer_if.slave bus
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    done_q, done_d;
  logic                    tick;
  logic                    wrap;
  timer_mode_t             mode;

  assign mode = timer_mode_t'(bus.one_shot);

  // Prescaler restarts on clear/load and freezes once a one-shot run has finished.
  flex_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (bus.clear | bus.load),
    .enable   (bus.enable & ~done_q),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  // Counter, wrap pulse and done registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  // Next state: clear > load > tick > hold; terminal compare precedes any arithmetic wrap.
  always_comb begin
    count_d = count_q;
    flag_d  = 1'b0;
    done_d  = done_q;
    wrap    = 1'b0;
    if (bus.clear) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (bus.load) begin
      count_d = bus.load_val;
      done_d  = 1'b0;
    end else if (tick) begin
      case (bus.count_down)
        DIR_UP: begin
          if (count_q >= bus.rollover_val) begin
            count_d = '0;
            wrap    = 1'b1;
          end else begin
            count_d = count_q + NUM_CNT_BITS'(1);
          end
        end
        DIR_DOWN: begin
          if (count_q == '0) begin
            count_d = bus.rollover_val;
            wrap    = 1'b1;
          end else begin
            count_d = count_q - NUM_CNT_BITS'(1);
          end
        end
      endcase
      flag_d = wrap;
      if (wrap && (mode == ONE_SHOT)) done_d = 1'b1;
    end
  end

  assign bus.count_out     = count_q;
  assign bus.rollover_flag = flag_q;
  assign bus.done          = done_q;
  assign bus.running       = bus.enable & ~done_q;

endmodule

// File: tb/tb_flex_timer.sv
// Scoreboard bench for flex_timer: reference model pushes expectations, monitor pops and compares.
module tb_flex_timer;

  localparam int unsigned W = 8;
  localparam int unsigned P = 4;

  logic clk;
  logic n_rst;

  flex_timer_if #(.NUM_CNT_BITS(W), .PRESCALE_BITS(P)) bus ();

  flex_timer #(.NUM_CNT_BITS(W), .PRESCALE_BITS(P)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    int count;
    bit flag;
    bit done;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_count = 0;
  int m_pcnt  = 0;
  bit m_done  = 0;
  bit m_flag  = 0;
  bit m_wrap  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timer behaviour in plain integer arithmetic.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_count = 0;
      m_pcnt  = 0;
      m_done  = 0;
      m_flag  = 0;
      sb_q.delete();
    end else begin
      m_flag = 0;
      if (bus.clear) begin
        m_count = 0;
        m_pcnt  = 0;
        m_done  = 0;
      end else if (bus.load) begin
        m_count = int'(bus.load_val);
        m_pcnt  = 0;
        m_done  = 0;
      end else if (bus.enable && !m_done) begin
        if (m_pcnt == int'(bus.prescale)) begin
          m_pcnt = 0;
          m_wrap = 0;
          if (bus.count_down) begin
            if (m_count == 0) begin
              m_count = int'(bus.rollover_val);
              m_wrap  = 1;
            end else begin
              m_count = m_count - 1;
            end
          end else begin
            if (m_count >= int'(bus.rollover_val)) begin
              m_count = 0;
              m_wrap  = 1;
            end else begin
              m_count = (m_count + 1) % (1 << W);
            end
          end
          m_flag = m_wrap;
          if (m_wrap && bus.one_shot) m_done = 1;
        end else begin
          m_pcnt = (m_pcnt + 1) % (1 << P);
        end
      end
      begin
        exp_t e;
        e.count = m_count;
        e.flag  = m_flag;
        e.done  = m_done;
        sb_q.push_back(e);
      end
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation mid-cycle.
  always @(negedge clk) begin
    if (n_rst && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sb_count", int'(bus.count_out), e.count);
      chk("sb_flag", int'(bus.rollover_flag), int'(e.flag));
      chk("sb_done", int'(bus.done), int'(e.done));
      chk("sb_running", int'(bus.running), int'(bus.enable & ~e.done));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_out(input string name, input int cnt, input int flg, input int dn);
    chk({name, "_count"}, int'(bus.count_out), cnt);
    chk({name, "_flag"}, int'(bus.rollover_flag), flg);
    chk({name, "_done"}, int'(bus.done), dn);
  endtask

  initial begin
    int seq[4];
    n_rst            = 1'b0;
    bus.clear        = 1'b0;
    bus.enable       = 1'b0;
    bus.count_down   = 1'b0;
    bus.one_shot     = 1'b0;
    bus.prescale     = '0;
    bus.rollover_val = '0;
    bus.load         = 1'b0;
    bus.load_val     = '0;
    #23;
    chk_out("reset", 0, 0, 0);
    chk("reset_running", int'(bus.running), 0);

    // Test 1: up, auto-reload, prescale 0, rollover 3.
    @(posedge clk); #1;
    n_rst            = 1'b1;
    bus.enable       = 1'b1;
    bus.rollover_val = 8'd3;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk_out("t1", i % 4, (i % 4 == 0) ? 1 : 0, 0);
    end

    // Test 2: down, prescale 2, rollover 5, start from loaded 2.
    bus.clear = 1'b1; step(1); bus.clear = 1'b0;
    bus.count_down   = 1'b1;
    bus.prescale     = 4'd2;
    bus.rollover_val = 8'd5;
    bus.load         = 1'b1;
    bus.load_val     = 8'd2;
    step(1);
    chk_out("t2_load", 2, 0, 0);
    bus.load = 1'b0;
    seq = '{2, 1, 0, 5};
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk_out("t2", seq[i / 3], (i == 9) ? 1 : 0, 0);
    end

    // Test 3: one-shot up, rollover 4.
    bus.clear = 1'b1; step(1); bus.clear = 1'b0;
    bus.count_down   = 1'b0;
    bus.one_shot     = 1'b1;
    bus.prescale     = 4'd0;
    bus.rollover_val = 8'd4;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      chk_out("t3_run", i % 5, (i == 5) ? 1 : 0, (i == 5) ? 1 : 0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_out("t3_hold", 0, 0, 1);
      chk("t3_running", int'(bus.running), 0);
    end
    bus.one_shot = 1'b0;
    step(1);
    chk("t3_done_sticky", int'(bus.done), 1);
    bus.one_shot = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 8'd1;
    step(1);
    chk_out("t3_reload", 1, 0, 0);
    chk("t3_running2", int'(bus.running), 1);
    bus.load = 1'b0;
    step(1);
    chk_out("t3_resume", 2, 0, 0);

    // Test 4: clear+load+tick at 7, then load+tick at terminal.
    bus.one_shot     = 1'b0;
    bus.rollover_val = 8'd10;
    bus.load         = 1'b1;
    bus.load_val     = 8'd7;
    step(1);
    chk("t4_at7", int'(bus.count_out), 7);
    bus.clear    = 1'b1;
    bus.load_val = 8'd9;
    step(1);
    chk_out("t4_clr_ld", 0, 0, 0);
    bus.clear    = 1'b0;
    bus.load_val = 8'd10;
    step(1);
    chk("t4_at_term", int'(bus.count_out), 10);
    bus.load_val = 8'd3;
    step(1);
    chk_out("t4_ld_term", 3, 0, 0);
    bus.load = 1'b0;

    // Test 5: rollover lowered below count, then rollover 0.
    bus.load     = 1'b1;
    bus.load_val = 8'd6;
    step(1);
    bus.load         = 1'b0;
    bus.rollover_val = 8'd2;
    step(1);
    chk_out("t5_lower", 0, 1, 0);
    bus.rollover_val = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk_out("t5_zero", 0, 1, 0);
    end

    // Test 6: async reset with count 5, done and flag all set.
    bus.one_shot     = 1'b1;
    bus.count_down   = 1'b1;
    bus.rollover_val = 8'd5;
    bus.load         = 1'b1;
    bus.load_val     = 8'd0;
    step(1);
    bus.load = 1'b0;
    step(1);
    chk_out("t6_pre", 5, 1, 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk_out("t6_async", 0, 0, 0);
    chk("t6_running", int'(bus.running), 1);
    bus.count_down = 1'b0;
    bus.one_shot   = 1'b0;
    #3;
    n_rst = 1'b1;
    step(1);
    chk_out("t6_restart", 1, 0, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bus.clear  = ($urandom_range(0, 99) < 3);
      bus.load   = ($urandom_range(0, 99) < 5);
      bus.enable = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 5) bus.count_down = ~bus.count_down;
      if ($urandom_range(0, 99) < 5) bus.one_shot = ~bus.one_shot;
      if ($urandom_range(0, 99) < 10)
        bus.prescale = ($urandom_range(0, 1) == 0) ? 4'd0 : P'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 8) bus.rollover_val = W'($urandom_range(0, 12));
      bus.load_val = W'($urandom_range(0, 255));
      step(1);
    end

    bus.clear = 1'b0;
    bus.load  = 1'b0;
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flex_timer.md
Name: flex_timer

Overview:
- Parametrised successor to the flex counter used across the I2C/APB peripherals.
- Adds up/down counting, an integrated prescaler, one-shot vs. auto-reload modes, synchronous load, and a sticky completion flag.
- Sits under the I2C register block, driven by SCL-period / timeout configuration registers.
- Outputs feed the bit-timing FSM and the timeout status bits.

Parameters:
- NUM_CNT_BITS, 8, width of the main counter, rollover_val and load_val.
- PRESCALE_BITS, 4, width of the prescale divider value.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear; highest priority.
- enable  in  1  counting enable; prescaler and counter hold when low.
- count_down  in  1  0 = count up, 1 = count down.
- one_shot  in  1  0 = auto-reload, 1 = stop after first wrap.
- prescale  in  PRESCALE_BITS  tick every prescale+1 enabled cycles.
- rollover_val  in  NUM_CNT_BITS  terminal value (up mode) / reload value (down mode).
- load  in  1  synchronous load strobe.
- load_val  in  NUM_CNT_BITS  value written to count_out on load.
- count_out  out  NUM_CNT_BITS  current count.
- rollover_flag  out  1  one-cycle pulse on wrap.
- done  out  1  sticky: set on one-shot wrap.
- running  out  1  enable & ~done.

Behaviour:
- Reset: count_out=0, rollover_flag=0, done=0, prescaler count=0. running follows reset values (= enable).
- Priority per cycle: clear > load > tick > hold.
- clear:
  - count_out←0, prescaler←0, done←0, rollover_flag←0 next cycle.
  - In down mode, clear also yields 0; the next tick wraps to rollover_val with a pulse.
- load:
  - count_out←load_val, prescaler←0, done←0, no rollover pulse.
  - load_val is not range-checked.
- Prescaler:
  - pcnt increments on each enable&~done cycle.
  - tick is asserted when pcnt==prescale; pcnt←0 on the same edge.
  - prescale=0 gives a tick every enabled cycle.
  - prescale changed mid-count: compared against the current pcnt; if pcnt>prescale, pcnt wraps through its full width, no special handling.
- Up-mode tick:
  - If count_out>=rollover_val: count_out←0 and wrap.
  - Else count_out+1.
- Down-mode tick:
  - If count_out==0: count_out←rollover_val and wrap.
  - Else count_out-1.
- Wrap effects:
  - rollover_flag=1 for exactly the cycle in which count_out shows the wrapped value (registered; 1-cycle latency from the tick edge).
  - Flag stays low otherwise.
- rollover_val=0: count_out stays 0; every tick is a wrap, so rollover_flag is high continuously while ticking with prescale=0.
- One-shot mode:
  - On wrap, done←1; count_out holds the wrapped value.
  - Further ticks are suppressed; the prescaler freezes.
  - done is cleared only by clear or load.
- Auto-reload mode: done never sets.
- If one_shot is deasserted while done=1, done stays set until clear/load.
- count_down and one_shot are sampled at each tick; changing them mid-count takes effect at the next tick.
- All arithmetic is modulo 2^NUM_CNT_BITS; there are no other wraps since the terminal compare precedes them.
- enable low: counter, prescaler and flags hold; rollover_flag returns to 0.

Decomposition:
- flex_timer_pkg holds:
  - localparam DIR_UP=1'b0, DIR_DOWN=1'b1;
  - typedef enum logic {AUTO_RELOAD, ONE_SHOT} timer_mode_t.
- Sub-module flex_prescaler(clk, n_rst, clear, enable, prescale → tick).
  - Its clear is driven by clear|load.
  - Its enable is driven by enable&~done.
- Main counter logic lives in flex_timer.

Test Plan:
1. Up, auto, prescale=0, rollover_val=3, enable=1 → count 0,1,2,3,0,1…; rollover_flag high exactly when count returns to 0, every 4 cycles.
2. Down, prescale=2, rollover_val=5, load_val=2 loaded → count changes every 3 cycles: 2,1,0,5,4…; one pulse at 5.
3. One-shot up, rollover_val=4, prescale=0 → 0..4, 0; done=1, running=0, count held at 0 for 10 cycles; load with load_val=1 → done=0, counting resumes from 1.
4. Simultaneous clear+load+tick at count=7 → count 0, no pulse. load+tick at terminal → count=load_val, no pulse.
5. rollover_val lowered from 10 to 2 while count=6 (up) → next tick gives 0 with a pulse. rollover_val=0 → pulse on every tick.
6. n_rst asserted mid-count (count=5, done=1, flag=1) → all outputs 0 asynchronously; after release with enable=1, counting restarts from 0.
